// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, a held data_valid/data_ack
// handshake, a sticky overrun flag and a one-cycle frame_err pulse.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | counting half a bit, then confirming the start bit is still low
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit, then holding one more cycle before IDLE
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [2:0]    sync_ok;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_seen;
    logic          start_edge;

    // Synchroniser plus previous-sample register. sync_ok marks when rx_prev
    // holds a real line sample rather than a reset value, so the line being low
    // right after reset release is never mistaken for a fresh start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            sync_ok <= 3'b000;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            sync_ok <= {sync_ok[1:0], 1'b1};
        end
    end

    assign start_edge = sync_ok[2] & rx_prev & ~rx_s;

    // Receive FSM with down-counting bit timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            stop_seen  <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // Consumer handshake; a good completion below overrides it.
            if (data_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state     <= START;
                        busy      <= 1'b1;
                        cnt       <= HALF_M1;
                        bit_idx   <= '0;
                        stop_seen <= 1'b0;
                    end
                end

                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state <= DATA;
                            cnt   <= BIT_M1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= BIT_M1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                STOP: begin
                    if (stop_seen) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        stop_seen <= 1'b0;
                    end else if (cnt == '0) begin
                        stop_seen <= 1'b1;
                        if (rx_s) begin
                            data       <= shreg;
                            data_valid <= 1'b1;
                            // An ack landing on the completion cycle consumes
                            // the old byte, so the new one is not an overrun.
                            overrun    <= data_valid & ~data_ack;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
